// File: rtl/lzw_input_sequencer.sv
// ROM-to-LZW-core input sequencer: prefetches ROM words into a small FIFO and
// streams truncated symbols to the core, flagging the final one.
module lzw_input_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int SYM_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  rom_cs,
    input  logic                  rom_valid,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  rom_eof,
    output logic                  sym_valid,
    output logic [SYM_WIDTH-1:0]  sym_data,
    output logic                  sym_last,
    input  logic                  sym_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  sym_count,
    output logic                  err_wide
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_1   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_2   = (PTR_W + 1)'(2);
    localparam logic [PTR_W-1:0] PTR_1   = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t               state;
    logic [SYM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       fifo_count;
    logic                 eof_seen;
    logic                 push;
    logic                 pop;
    logic                 upper_nz;

    // rom_cs looks only at the registered count, so a full FIFO never accepts
    // a word even when the head is popped on the same edge.
    assign rom_cs    = (state == FETCH) && rom_valid && (fifo_count < DEPTH_C);
    assign push      = rom_cs && !abort;
    // The last buffered entry is held back until eof tells us it is the final one.
    assign sym_valid = (fifo_count >= CNT_2) || ((fifo_count == CNT_1) && eof_seen);
    assign sym_last  = sym_valid && (fifo_count == CNT_1) && eof_seen;
    assign pop       = sym_valid && sym_ready && !abort;
    assign sym_data  = (fifo_count != '0) ? mem[rd_ptr] : '0;
    assign upper_nz  = |(rom_data >> SYM_WIDTH);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rom_data[SYM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            eof_seen   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sym_count  <= '0;
            err_wide   <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            eof_seen   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_1;
                if (upper_nz) begin
                    err_wide <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_1;
                if (sym_count != '1) begin
                    sym_count <= sym_count + CNT_WIDTH'(1);
                end
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_1;
                2'b01:   fifo_count <= fifo_count - CNT_1;
                default: ;
            endcase

            unique case (state)
                IDLE: begin
                    if (start) begin
                        sym_count <= '0;
                        err_wide  <= 1'b0;
                        eof_seen  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!rom_valid && rom_eof) begin
                        eof_seen <= 1'b1;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_count == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lzw_input_sequencer.sv
// Directed and randomized bench for lzw_input_sequencer with a ROM stub and a
// queue-based reference of the expected symbol stream.
module tb_lzw_input_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rom_cs;
    logic        rom_valid;
    logic [63:0] rom_data;
    logic        rom_eof;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_last;
    logic        sym_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [12:0] sym_count;
    logic        err_wide;

    lzw_input_sequencer #(
        .DATA_WIDTH(64),
        .SYM_WIDTH (8),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (13)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .rom_cs   (rom_cs),
        .rom_valid(rom_valid),
        .rom_data (rom_data),
        .rom_eof  (rom_eof),
        .sym_valid(sym_valid),
        .sym_data (sym_data),
        .sym_last (sym_last),
        .sym_ready(sym_ready),
        .busy     (busy),
        .done     (done),
        .sym_count(sym_count),
        .err_wide (err_wide)
    );

    always #5 clk = ~clk;

    // ROM stub: word array, advances when rom_cs && rom_valid, rewinds on start
    logic [63:0] rom_mem [64];
    int          rom_len = 0;
    int          rom_idx = 0;
    logic        gate = 1'b1;

    always @(posedge clk) begin
        if (start) rom_idx <= 0;
        else if (rom_cs && rom_valid) rom_idx <= rom_idx + 1;
    end

    assign rom_valid = (rom_idx < rom_len) && gate;
    assign rom_eof   = (rom_idx >= rom_len);
    assign rom_data  = (rom_idx < rom_len) ? rom_mem[rom_idx[5:0]] : 64'h0;

    // Observed stream, sampled on the falling edge
    logic [7:0] got_d [$];
    logic       got_l [$];
    int         done_cnt = 0;
    bit         valid_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (sym_valid && sym_ready && !abort) begin
                got_d.push_back(sym_data);
                got_l.push_back(sym_last);
            end
            if (done) done_cnt++;
            if (sym_valid) valid_seen = 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0: hold, 1: alternate every cycle
    int gate_mode = 0;  // 0: ROM always ready, 1: rom_valid toggles

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_mode == 1) sym_ready = ~sym_ready;
        if (gate_mode == 1) gate = ~gate;
    endtask

    task automatic load_str(input string s);
        rom_len = s.len();
        for (int i = 0; i < rom_len; i++) rom_mem[i] = 64'(s[i]);
    endtask

    task automatic load_rand(input int len);
        rom_len = len;
        for (int i = 0; i < len; i++) rom_mem[i] = 64'(8'($urandom));
    endtask

    task automatic begin_pass();
        got_d.delete();
        got_l.delete();
        done_cnt   = 0;
        valid_seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait for done, then compare against the expected stream derived from rom_mem
    task automatic finish_pass(input string tag);
        int n = 0;
        bit exp_err = 0;
        while (done_cnt == 0 && n < 400) begin
            step();
            n++;
        end
        chk({tag, ":done_seen"}, 64'(done_cnt != 0), 64'd1);
        step();
        step();
        for (int i = 0; i < rom_len; i++) if (rom_mem[i][63:8] != 56'h0) exp_err = 1;
        chk({tag, ":beats"}, 64'(got_d.size()), 64'(rom_len));
        for (int i = 0; i < rom_len && i < got_d.size(); i++) begin
            chk($sformatf("%s:data%0d", tag, i), 64'(got_d[i]), 64'(rom_mem[i][7:0]));
            chk($sformatf("%s:last%0d", tag, i), 64'(got_l[i]), 64'(i == rom_len - 1));
        end
        chk({tag, ":sym_count"}, 64'(sym_count), 64'(rom_len));
        chk({tag, ":done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, ":busy_after"}, 64'(busy), 64'd0);
        chk({tag, ":done_low"}, 64'(done), 64'd0);
        chk({tag, ":err_wide"}, 64'(err_wide), 64'(exp_err));
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst:rom_cs", 64'(rom_cs), 64'd0);
        chk("rst:sym_valid", 64'(sym_valid), 64'd0);
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:done", 64'(done), 64'd0);
        chk("rst:sym_count", 64'(sym_count), 64'd0);
        chk("rst:sym_data", 64'(sym_data), 64'd0);
        #4 rst_n = 1'b1;
        step();

        // Nominal file with first-beat latency
        load_str("ABBABBBABBA");
        sym_ready = 1'b1;
        begin_pass();
        chk("nom:rom_cs_E0", 64'(rom_cs), 64'd1);
        chk("nom:busy_E0", 64'(busy), 64'd1);
        chk("nom:valid_E0", 64'(sym_valid), 64'd0);
        step();
        chk("nom:valid_E1", 64'(sym_valid), 64'd0);
        step();
        chk("nom:valid_E2", 64'(sym_valid), 64'd1);
        finish_pass("nom");

        // Backpressure: FIFO fills, rom_cs stays low
        sym_ready = 1'b0;
        begin_pass();
        for (int i = 0; i < 10; i++) step();
        chk("bp:rom_words_taken", 64'(rom_idx), 64'd4);
        chk("bp:rom_cs_full", 64'(rom_cs), 64'd0);
        chk("bp:valid_full", 64'(sym_valid), 64'd1);
        sym_ready = 1'b1;
        finish_pass("bp");

        // Empty file
        rom_len = 0;
        begin_pass();
        finish_pass("empty");
        chk("empty:no_valid", 64'(valid_seen), 64'd0);

        // Wide third word
        load_rand(8);
        rom_mem[2] = 64'h1_0000_0042;
        begin_pass();
        for (int n = 0; rom_idx < 2 && n < 20; n++) step();
        chk("wide:err_before", 64'(err_wide), 64'd0);
        step();
        chk("wide:err_after", 64'(err_wide), 64'd1);
        finish_pass("wide");
        if (got_d.size() > 2) chk("wide:sym3", 64'(got_d[2]), 64'h42);

        // Abort after five accepted symbols
        load_rand(11);
        begin_pass();
        for (int n = 0; got_d.size() < 5 && n < 50; n++) step();
        chk("abort:reached5", 64'(got_d.size()), 64'd5);
        sym_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort:sym_valid", 64'(sym_valid), 64'd0);
        chk("abort:busy", 64'(busy), 64'd0);
        chk("abort:rom_cs", 64'(rom_cs), 64'd0);
        chk("abort:sym_count", 64'(sym_count), 64'd5);
        for (int i = 0; i < 4; i++) step();
        chk("abort:no_done", 64'(done_cnt), 64'd0);
        chk("abort:count_hold", 64'(sym_count), 64'd5);

        // Asynchronous reset mid-FETCH, then a normal pass
        load_rand(12);
        rom_mem[0] = 64'hFF00_0000_0011;
        sym_ready = 1'b1;
        begin_pass();
        step();
        step();
        step();
        chk("rst2:count_before", 64'(sym_count), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2:rom_cs", 64'(rom_cs), 64'd0);
        chk("rst2:sym_valid", 64'(sym_valid), 64'd0);
        chk("rst2:sym_last", 64'(sym_last), 64'd0);
        chk("rst2:busy", 64'(busy), 64'd0);
        chk("rst2:sym_count", 64'(sym_count), 64'd0);
        chk("rst2:err_wide", 64'(err_wide), 64'd0);
        chk("rst2:sym_data", 64'(sym_data), 64'd0);
        #2 rst_n = 1'b1;
        step();
        load_rand(9);
        begin_pass();
        finish_pass("post_rst");

        // Alternating sym_ready against a toggling rom_valid, random files
        rdy_mode  = 1;
        gate_mode = 1;
        for (int k = 0; k < 4; k++) begin
            load_rand(int'($urandom_range(1, 20)));
            sym_ready = 1'b1;
            gate = 1'b1;
            begin_pass();
            finish_pass($sformatf("alt%0d", k));
        end
        rdy_mode  = 0;
        gate_mode = 0;
        gate = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
